// File: rtl/object_fetch_unit.sv
// ---------------------------------------------------------------------------
// object_fetch_unit
//
// Fetches a tagged heap object for the eval FSM. A request carries the
// object's base address. The unit reads the tag word, works out how many
// field words follow, and reads those fields one at a time into a response
// buffer. It then presents tag, fields and a status code on a valid/ready
// response channel. Only one memory read is outstanding at any time.
//
// Each word read takes READ_LATENCY+1 cycles:
//   - one ISSUE cycle that registers mem_addr;
//   - READ_LATENCY-1 WAIT cycles;
//   - one CAPTURE cycle that samples mem_rdata.
// The CAPTURE edge is therefore READ_LATENCY edges after mem_addr changed.
//
// Tag encodings are parameters so that integration can match the core's
// type table. The tag comparison uses the whole tag word.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   req_valid     request present
//   req_ready     unit idle and able to accept (0 while rst is high)
//   req_addr      object base address (address of the tag word)
//   req_tag_only  1 = return the tag and field count only, read no fields
//   mem_addr      registered read address to memory_controller
//   mem_rdata     read data, valid READ_LATENCY cycles after mem_addr changes
//   mem_error     memory_controller error flag
//   resp_valid    response held valid until accepted
//   resp_ready    consumer accepts the response
//   resp_tag      fetched tag word
//   resp_fields   field i at [i*DATA_WIDTH +: DATA_WIDTH]; unused slots are 0
//   resp_nfields  number of valid fields
//   resp_err      0 OK, 1 BAD_TAG, 2 MEM_ERR, 3 ADDR_OVF
// ---------------------------------------------------------------------------
module object_fetch_unit #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int MAX_FIELDS   = 3,
  parameter int READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] TAG_NUMBER    = DATA_WIDTH'(1),
  parameter logic [DATA_WIDTH-1:0] TAG_CONS      = DATA_WIDTH'(2),
  parameter logic [DATA_WIDTH-1:0] TAG_FUNC_PRIM = DATA_WIDTH'(3),
  parameter logic [DATA_WIDTH-1:0] TAG_FUNC      = DATA_WIDTH'(4)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic                             req_tag_only,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  input  logic [DATA_WIDTH-1:0]            mem_rdata,
  input  logic                             mem_error,
  output logic                             resp_valid,
  input  logic                             resp_ready,
  output logic [DATA_WIDTH-1:0]            resp_tag,
  output logic [MAX_FIELDS*DATA_WIDTH-1:0] resp_fields,
  output logic [1:0]                       resp_nfields,
  output logic [1:0]                       resp_err
);

  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_BAD_TAG  = 2'd1;
  localparam logic [1:0] ERR_MEM      = 2'd2;
  localparam logic [1:0] ERR_ADDR_OVF = 2'd3;

  localparam int              CNT_W  = 3;
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_RESP
  } state_t;

  state_t                          state_q, state_d;
  logic [ADDR_WIDTH-1:0]           base_q, base_d;
  logic [ADDR_WIDTH-1:0]           mem_addr_q, mem_addr_d;
  logic                            tag_only_q, tag_only_d;
  logic [1:0]                      k_q, k_d;        // word index: 0 = tag, i = field i-1
  logic [1:0]                      n_q, n_d;        // field count of the current object
  logic [CNT_W-1:0]                cnt_q, cnt_d;    // remaining WAIT cycles
  logic [DATA_WIDTH-1:0]           tag_q, tag_d;
  logic [MAX_FIELDS*DATA_WIDTH-1:0] fields_q, fields_d;
  logic [1:0]                      nfields_q, nfields_d;
  logic [1:0]                      err_q, err_d;

  // Field count implied by the word currently on mem_rdata. The result is
  // only used in the CAPTURE cycle of the tag word.
  logic       tag_known;
  logic [1:0] tag_n;

  always_comb begin
    tag_known = 1'b1;
    tag_n     = 2'd0;
    if (mem_rdata == TAG_NUMBER) begin
      tag_n = 2'd1;
    end else if (mem_rdata == TAG_CONS) begin
      tag_n = 2'd2;
    end else if (mem_rdata == TAG_FUNC_PRIM) begin
      tag_n = 2'd1;
    end else if (mem_rdata == TAG_FUNC) begin
      tag_n = 2'd3;
    end else begin
      tag_known = 1'b0;
    end
    // An object that cannot fit the response buffer is treated as malformed.
    if (int'(tag_n) > MAX_FIELDS) begin
      tag_known = 1'b0;
    end
  end

  // The object's last word is base+n. One extra bit catches a carry out of
  // the address space, which would otherwise wrap back to low memory.
  logic [ADDR_WIDTH:0] end_addr;
  logic                addr_ovf;

  assign end_addr = {1'b0, base_q} + {{(ADDR_WIDTH - 1){1'b0}}, tag_n};
  assign addr_ovf = end_addr[ADDR_WIDTH];

  // Field word k lands in slot k-1.
  logic [MAX_FIELDS-1:0] slot_sel;

  for (genvar gi = 0; gi < MAX_FIELDS; gi++) begin : g_slot
    assign slot_sel[gi] = (k_q == 2'(gi + 1));
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    mem_addr_d = mem_addr_q;
    tag_only_d = tag_only_q;
    k_d        = k_q;
    n_d        = n_q;
    cnt_d      = cnt_q;
    tag_d      = tag_q;
    fields_d   = fields_q;
    nfields_d  = nfields_q;
    err_d      = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          base_d     = req_addr;
          tag_only_d = req_tag_only;
          tag_d      = '0;
          fields_d   = '0;
          nfields_d  = 2'd0;
          err_d      = ERR_OK;
          k_d        = 2'd0;
          n_d        = 2'd0;
          state_d    = S_ISSUE;
        end
      end

      S_ISSUE, S_WAIT, S_CAPTURE: begin
        if (mem_error) begin
          // Any partial field data belongs to a failed fetch and is dropped.
          err_d     = ERR_MEM;
          fields_d  = '0;
          nfields_d = 2'd0;
          state_d   = S_RESP;
        end else if (state_q == S_ISSUE) begin
          mem_addr_d = base_q + ADDR_WIDTH'(k_q);
          cnt_d      = LAT_M1;
          state_d    = (LAT_M1 == '0) ? S_CAPTURE : S_WAIT;
        end else if (state_q == S_WAIT) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_CAPTURE;
          end
        end else if (k_q == 2'd0) begin
          tag_d = mem_rdata;
          if (!tag_known) begin
            err_d   = ERR_BAD_TAG;
            state_d = S_RESP;
          end else if (addr_ovf) begin
            err_d   = ERR_ADDR_OVF;
            state_d = S_RESP;
          end else if (tag_only_q) begin
            nfields_d = tag_n;
            state_d   = S_RESP;
          end else begin
            n_d     = tag_n;
            k_d     = 2'd1;
            state_d = S_ISSUE;
          end
        end else begin
          for (int i = 0; i < MAX_FIELDS; i++) begin
            if (slot_sel[i]) begin
              fields_d[i*DATA_WIDTH +: DATA_WIDTH] = mem_rdata;
            end
          end
          if (k_q == n_q) begin
            nfields_d = n_q;
            err_d     = ERR_OK;
            state_d   = S_RESP;
          end else begin
            k_d     = k_q + 2'd1;
            state_d = S_ISSUE;
          end
        end
      end

      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      mem_addr_q <= '0;
      tag_only_q <= 1'b0;
      k_q        <= 2'd0;
      n_q        <= 2'd0;
      cnt_q      <= '0;
      tag_q      <= '0;
      fields_q   <= '0;
      nfields_q  <= 2'd0;
      err_q      <= ERR_OK;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      mem_addr_q <= mem_addr_d;
      tag_only_q <= tag_only_d;
      k_q        <= k_d;
      n_q        <= n_d;
      cnt_q      <= cnt_d;
      tag_q      <= tag_d;
      fields_q   <= fields_d;
      nfields_q  <= nfields_d;
      err_q      <= err_d;
    end
  end

  // req_ready is held low while rst is high, even in the first reset cycle,
  // before the state register has been cleared.
  assign req_ready    = (state_q == S_IDLE) && !rst;
  assign resp_valid   = (state_q == S_RESP);
  assign mem_addr     = mem_addr_q;
  assign resp_tag     = tag_q;
  assign resp_fields  = fields_q;
  assign resp_nfields = nfields_q;
  assign resp_err     = err_q;

endmodule

// File: tb/tb_object_fetch_unit.sv
// Bench for object_fetch_unit. It runs two instances, one with
// READ_LATENCY=1 and one with READ_LATENCY=3, both with ADDR_WIDTH=8.
// The two instances share a word-addressed memory model. Expected responses
// come from a reference model that applies the object rules directly to
// that memory image.
module tb_object_fetch_unit;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int MF = 3;
  localparam logic [DW-1:0] T_NUM  = 16'h0001;
  localparam logic [DW-1:0] T_CONS = 16'h0002;
  localparam logic [DW-1:0] T_PRIM = 16'h0003;
  localparam logic [DW-1:0] T_FUNC = 16'h0004;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]                 req_valid, req_ready, req_tag_only;
  logic [1:0]                 mem_error, resp_valid, resp_ready;
  logic [1:0][AW-1:0]         req_addr, mem_addr;
  logic [1:0][DW-1:0]         mem_rdata, resp_tag;
  logic [1:0][MF*DW-1:0]      resp_fields;
  logic [1:0][1:0]            resp_nfields, resp_err;

  logic [DW-1:0] mem [256];

  int n_checks = 0;
  int n_fail   = 0;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int RL = (gi == 0) ? 1 : 3;

    object_fetch_unit #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_FIELDS(MF), .READ_LATENCY(RL),
      .TAG_NUMBER(T_NUM), .TAG_CONS(T_CONS), .TAG_FUNC_PRIM(T_PRIM), .TAG_FUNC(T_FUNC)
    ) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[gi]), .req_ready(req_ready[gi]),
      .req_addr(req_addr[gi]), .req_tag_only(req_tag_only[gi]),
      .mem_addr(mem_addr[gi]), .mem_rdata(mem_rdata[gi]), .mem_error(mem_error[gi]),
      .resp_valid(resp_valid[gi]), .resp_ready(resp_ready[gi]),
      .resp_tag(resp_tag[gi]), .resp_fields(resp_fields[gi]),
      .resp_nfields(resp_nfields[gi]), .resp_err(resp_err[gi])
    );

    // Memory: data for an address is valid RL clock edges after mem_addr changes.
    if (RL == 1) begin : g_mem
      assign mem_rdata[gi] = mem[mem_addr[gi]];
    end else begin : g_mem
      logic [AW-1:0] pipe [RL-1];
      always @(posedge clk) begin
        pipe[0] <= mem_addr[gi];
        for (int s = 1; s < RL - 1; s++) pipe[s] <= pipe[s-1];
      end
      assign mem_rdata[gi] = mem[pipe[RL-2]];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put_obj(input logic [AW-1:0] a, input logic [DW-1:0] t,
                         input logic [DW-1:0] f0, input logic [DW-1:0] f1,
                         input logic [DW-1:0] f2);
    logic [DW-1:0] fv [3];
    fv[0] = f0; fv[1] = f1; fv[2] = f2;
    mem[a] = t;
    for (int i = 0; i < 3; i++)
      if (int'(a) + 1 + i <= 255) mem[int'(a) + 1 + i] = fv[i];
  endtask

  // Reference model: object rules applied to the memory image.
  task automatic model(input int d, input logic [AW-1:0] addr, input bit tonly,
                       output logic [DW-1:0] tag, output int n, output int err,
                       output int reads, output logic [MF*DW-1:0] f, output int lat);
    int rl;
    int cnt;
    rl    = (d == 0) ? 1 : 3;
    tag   = mem[addr];
    f     = '0;
    reads = 0;
    err   = 0;
    n     = 0;
    case (tag)
      T_NUM:   cnt = 1;
      T_CONS:  cnt = 2;
      T_PRIM:  cnt = 1;
      T_FUNC:  cnt = 3;
      default: cnt = -1;
    endcase
    if (cnt < 0) begin
      err = 1;
    end else if (int'(addr) + cnt > 255) begin
      err = 3;
    end else begin
      n = cnt;
      if (!tonly) begin
        reads = cnt;
        for (int i = 0; i < cnt; i++) f[i*DW +: DW] = mem[int'(addr) + 1 + i];
      end
    end
    lat = (reads + 1) * (rl + 1) + 1;
  endtask

  // One complete request/response transaction on instance d.
  // err_cyc > 0 pulses mem_error in that cycle after the accept edge.
  task automatic do_fetch(input int d, input logic [AW-1:0] addr, input bit tonly,
                          input int stall, input int err_cyc, input string nm);
    logic [DW-1:0]    e_tag;
    int               e_n, e_err, e_reads, e_lat;
    logic [MF*DW-1:0] e_f;
    logic [AW-1:0]    seen [$];
    logic [AW-1:0]    last, prev;
    int               cyc;
    bit               got;

    model(d, addr, tonly, e_tag, e_n, e_err, e_reads, e_f, e_lat);
    if (err_cyc > 0) begin
      e_err = 2;
      e_n   = 0;
      e_f   = '0;
    end

    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = req_ready[d];
    end
    check({nm, ":req_ready_idle"}, 64'(got), 64'd1);
    if (!got) return;

    req_valid[d]    = 1'b1;
    req_addr[d]     = addr;
    req_tag_only[d] = tonly;
    prev = mem_addr[d];
    last = prev;
    @(negedge clk);
    req_valid[d]    = 1'b0;
    req_addr[d]     = AW'($urandom);
    req_tag_only[d] = 1'($urandom);

    got = 1'b0;
    cyc = 0;
    for (int c = 1; c <= 120 && !got; c++) begin
      if (c > 1) @(negedge clk);
      if (mem_addr[d] !== last) begin
        seen.push_back(mem_addr[d]);
        last = mem_addr[d];
      end
      if (resp_valid[d]) begin
        got = 1'b1;
        cyc = c;
      end
      mem_error[d] = (c == err_cyc);
    end
    mem_error[d] = 1'b0;
    check({nm, ":resp_valid_seen"}, 64'(got), 64'd1);
    if (!got) return;
    if (err_cyc == 0) check({nm, ":latency"}, 64'(cyc), 64'(e_lat));

    for (int s = 0; s <= stall; s++) begin
      if (s > 0) @(negedge clk);
      check({nm, ":resp_valid"}, 64'(resp_valid[d]), 64'd1);
      check({nm, ":req_ready_resp"}, 64'(req_ready[d]), 64'd0);
      check({nm, ":err"}, 64'(resp_err[d]), 64'(e_err));
      check({nm, ":nfields"}, 64'(resp_nfields[d]), 64'(e_n));
      check({nm, ":fields"}, 64'(resp_fields[d]), 64'(e_f));
      if (err_cyc == 0) check({nm, ":tag"}, 64'(resp_tag[d]), 64'(e_tag));
      resp_ready[d] = (s == stall);
    end
    @(negedge clk);
    resp_ready[d] = 1'b0;
    check({nm, ":resp_valid_after"}, 64'(resp_valid[d]), 64'd0);
    check({nm, ":req_ready_after"}, 64'(req_ready[d]), 64'd1);

    if (err_cyc == 0 && prev != addr) begin
      check({nm, ":nreads"}, 64'(seen.size()), 64'(e_reads + 1));
      for (int i = 0; i < seen.size() && i <= e_reads; i++)
        check({nm, ":mem_addr_seq"}, 64'(seen[i]), 64'(int'(addr) + i));
    end
    $display("fetch %s dut%0d addr=%02h tag_only=%0d err=%0d nfields=%0d lat=%0d stall=%0d",
             nm, d, addr, tonly, resp_err[d], resp_nfields[d], cyc, stall);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] ra;
    logic [DW-1:0] rt;
    int            sel;

    req_valid = '0; req_tag_only = '0; mem_error = '0; resp_ready = '0; req_addr = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    rst = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst:req_ready", 64'(req_ready[d]), 64'd0);
      check("rst:resp_valid", 64'(resp_valid[d]), 64'd0);
      check("rst:mem_addr", 64'(mem_addr[d]), 64'd0);
      check("rst:resp_tag", 64'(resp_tag[d]), 64'd0);
      check("rst:resp_fields", 64'(resp_fields[d]), 64'd0);
      check("rst:resp_nfields", 64'(resp_nfields[d]), 64'd0);
      check("rst:resp_err", 64'(resp_err[d]), 64'd0);
    end
    rst = 1'b0;
    #1;
    check("rst:req_ready_release0", 64'(req_ready[0]), 64'd1);
    check("rst:req_ready_release1", 64'(req_ready[1]), 64'd1);

    // Number, RL=1
    put_obj(8'h10, T_NUM, 16'h002A, 16'h0, 16'h0);
    do_fetch(0, 8'h10, 1'b0, 0, 0, "number");
    // Cons, RL=3, consumer stalls for 10 cycles
    put_obj(8'h20, T_CONS, 16'h0030, 16'h0040, 16'h0);
    do_fetch(1, 8'h20, 1'b0, 10, 0, "cons_stall");
    // Closure, then a tag-only fetch of the same object
    put_obj(8'h50, T_FUNC, 16'h1111, 16'h2222, 16'h3333);
    do_fetch(0, 8'h50, 1'b0, 0, 0, "closure");
    do_fetch(0, 8'h50, 1'b1, 2, 0, "closure_tag_only");
    do_fetch(1, 8'h50, 1'b1, 0, 0, "closure_tag_only_rl3");
    // Unknown tag, followed by a normal fetch
    mem[8'h60] = 16'hBEEF;
    do_fetch(1, 8'h60, 1'b0, 1, 0, "bad_tag");
    do_fetch(1, 8'h10, 1'b0, 0, 0, "after_bad_tag");
    // Object would wrap the address space
    put_obj(8'hFF, T_CONS, 16'h0, 16'h0, 16'h0);
    do_fetch(0, 8'hFF, 1'b0, 0, 0, "addr_ovf_rl1");
    do_fetch(1, 8'hFF, 1'b0, 0, 0, "addr_ovf_rl3");
    // mem_error during the car read (RL=3) and during the tag read (RL=1)
    do_fetch(1, 8'h20, 1'b0, 0, 6, "mem_err_car");
    do_fetch(0, 8'h10, 1'b0, 0, 2, "mem_err_tag");
    do_fetch(1, 8'h20, 1'b0, 0, 0, "after_mem_err");

    // Reset in the WAIT state of the car read on the RL=3 instance
    put_obj(8'h20, T_CONS, 16'hA5A5, 16'h5A5A, 16'h0);
    @(negedge clk);
    req_valid[1] = 1'b1; req_addr[1] = 8'h20; req_tag_only[1] = 1'b0;
    @(negedge clk);
    req_valid[1] = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid:req_ready_in_rst", 64'(req_ready[1]), 64'd0);
    @(negedge clk);
    check("rst_mid:resp_valid", 64'(resp_valid[1]), 64'd0);
    check("rst_mid:mem_addr", 64'(mem_addr[1]), 64'd0);
    check("rst_mid:resp_fields", 64'(resp_fields[1]), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid:req_ready_after", 64'(req_ready[1]), 64'd1);
    check("rst_mid:resp_valid_after", 64'(resp_valid[1]), 64'd0);
    $display("reset applied mid-fetch on dut1");
    do_fetch(1, 8'h20, 1'b0, 0, 0, "after_reset");

    // Random objects
    for (int t = 0; t < 40; t++) begin
      ra  = AW'($urandom);
      sel = $urandom_range(0, 4);
      case (sel)
        0:       rt = T_NUM;
        1:       rt = T_CONS;
        2:       rt = T_PRIM;
        3:       rt = T_FUNC;
        default: rt = DW'($urandom_range(5, 65535));
      endcase
      put_obj(ra, rt, DW'($urandom), DW'($urandom), DW'($urandom));
      do_fetch(t % 2, ra, ($urandom_range(0, 3) == 0), $urandom_range(0, 3), 0, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/object_fetch_unit.md
Name: object_fetch_unit

Overview:
- Parametrised successor of the core's inline tagged-object fetch FSM.
- Accepts an object address over a valid/ready request channel and reads the tag word.
- Derives the field count from the tag, then reads each field sequentially into a response buffer.
- Returns tag, fields and status over a valid/ready response channel.
- Sits between the eval FSM and memory_controller, with configurable memory read latency and an optional tag-only mode.

Parameters:
ADDR_WIDTH, lisp::addr_width, memory address width
DATA_WIDTH, lisp::data_width, memory word width
MAX_FIELDS, 3, response field slots (closure body/args/env is the widest object)
READ_LATENCY, 1, cycles from mem_addr change to valid mem_rdata; range 1..7

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req_valid  in  1  fetch request present
req_ready  out  1  unit idle and able to accept
req_addr  in  ADDR_WIDTH  object base address (tag word)
req_tag_only  in  1  1 = fetch tag only, skip fields
mem_addr  out  ADDR_WIDTH  registered read address to memory_controller
mem_rdata  in  DATA_WIDTH  memory read data
mem_error  in  1  memory_controller error flag
resp_valid  out  1  response held valid
resp_ready  in  1  consumer accepts response
resp_tag  out  DATA_WIDTH  fetched tag word
resp_fields  out  MAX_FIELDS*DATA_WIDTH  field i at bits [i*DATA_WIDTH +: DATA_WIDTH]
resp_nfields  out  2  number of valid fields
resp_err  out  2  0 OK, 1 BAD_TAG, 2 MEM_ERR, 3 ADDR_OVF

Behaviour:
- Reset:
  - req_ready=0 during reset, 1 from the first cycle after.
  - resp_valid=0; resp_tag, resp_fields, resp_nfields, resp_err, mem_addr all =0.
  - Reset mid-operation aborts the fetch silently; no response is produced.
- States: IDLE, ISSUE, WAIT, CAPTURE, RESP.
- IDLE: req_ready=1. On req_valid&req_ready:
  - latch req_addr and req_tag_only;
  - clear resp_fields;
  - set word index k=0;
  - go to ISSUE.
- ISSUE: mem_addr <= base+k (registered); load the latency counter with READ_LATENCY-1; go to WAIT.
- WAIT: decrement the counter; at 0 go to CAPTURE.
- CAPTURE: sample mem_rdata.
  - mem_error high in any ISSUE/WAIT/CAPTURE cycle latches resp_err=MEM_ERR and goes to RESP; the data is discarded.
- Tag word (k=0): store to resp_tag and decode field count n:
  - TYPE_NUMBER=1, TYPE_CONS=2, TYPE_FUNC_PRIM=1, TYPE_FUNC=3;
  - any other tag: resp_err=BAD_TAG, resp_nfields=0, go to RESP;
  - if base+n > 2^ADDR_WIDTH-1 (the object would wrap the address space): resp_err=ADDR_OVF, no field reads, go to RESP;
  - if tag_only: resp_nfields=n, go to RESP.
- Field words (k>=1): store to field slot k-1.
  - If k==n: resp_nfields=n, resp_err=OK, go to RESP.
  - Otherwise k++ and go to ISSUE.
- Only one read is outstanding at a time; mem_addr holds its value between reads.
- Latency:
  - resp_valid rises exactly (n+1)*(READ_LATENCY+1)+1 cycles after the accept cycle;
  - tag-only and tag errors use n=0 in that formula.
- RESP: resp_valid=1 and all resp_* outputs stable until resp_valid&resp_ready, then IDLE.
  - Consumer backpressure is unbounded.
  - req_ready=0 throughout RESP.
  - A request presented in the same cycle as the handshake is not accepted until the next cycle.
- Field slots beyond resp_nfields read 0.
- resp_err stays 0 unless set by the current fetch.
- Error codes are per-response: the unit never locks up and the next request runs normally.
- req_addr and req_tag_only are ignored outside IDLE.

Test Plan:
- RL=1, mem[0x10]=TYPE_NUMBER, mem[0x11]=0x002A, req_addr=0x10 -> resp_valid 5 cycles after accept; resp_tag=TYPE_NUMBER, nfields=1, field0=0x002A, err=0.
- RL=3, cons at 0x20, car=0x0030, cdr=0x0040; resp_ready held low 10 cycles -> resp_valid after 13 cycles; outputs stable while stalled; req_ready=0 until the handshake.
- Closure (TYPE_FUNC) at 0x50, fields 0x1111/0x2222/0x3333 -> nfields=3, fields in order, mem_addr sequence 0x50,0x51,0x52,0x53; then tag_only fetch of the same address -> nfields=3, fields all 0, resp_valid after (RL+1)+1 cycles.
- mem[0x60]=0xBEEF (unknown tag) -> err=1, nfields=0; next NUMBER request completes with err=0.
- ADDR_WIDTH=8, cons at 0xFF -> err=3, no field read issued; mem_error pulsed during the car read of a cons at 0x20 -> err=2.
- rst asserted in the WAIT state of a field read -> next cycle resp_valid=0, then req_ready=1; a fresh fetch completes correctly.
